core_mem_arbiter: RTL and testbench

- Shares one memory request channel between the core's instruction-fetch port (read-only) and data port (read/write).
- Sits between the core pipeline and the AXI memory bridge, in the CCLK domain.
- Round-robin arbitration, one outstanding transaction at a time, registered response return.
- Provides the MEM_WAIT stall indication the core consumes.

---
 rtl/core_mem_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/core_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core memory-port arbiter.
package core_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef logic gnt_t;

  localparam gnt_t GNT_I = 1'b0;
  localparam gnt_t GNT_D = 1'b1;

  // Read data returned when the downstream side never answers.
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

  // The port that did not win the previous grant.
  function automatic gnt_t other_port(input gnt_t g);
    return (g == GNT_I) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: alternates on contention, otherwise grants the lone requester.
module rr_arb2
  import core_mem_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  gnt_t last_i,
  output gnt_t gnt_c_o
);

  // Both asking: the port not served last wins; single request wins outright.
  always_comb begin
    gnt_c_o = GNT_I;
    if (i_req_i && d_req_i) begin
      gnt_c_o = other_port(last_i);
    end else if (d_req_i) begin
      gnt_c_o = GNT_D;
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one downstream memory channel between the fetch (read-only) and data ports.
// One transaction in flight; IDLE -> CMD -> RESP. Optional CMD watchdog and ERR
// output are enabled by the CORE_MEM_TIMEOUT_EN macro.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    CCLK,
  input  logic                    CRST,
  input  logic                    I_REQ,
  input  logic [ADDR_WIDTH-1:0]   I_ADDR,
  output logic                    I_ACK,
  output logic [DATA_WIDTH-1:0]   I_RDATA,
  input  logic                    D_REQ,
  input  logic                    D_WE,
  input  logic [ADDR_WIDTH-1:0]   D_ADDR,
  input  logic [DATA_WIDTH-1:0]   D_WDATA,
  input  logic [DATA_WIDTH/8-1:0] D_STRB,
  output logic                    D_ACK,
  output logic [DATA_WIDTH-1:0]   D_RDATA,
  output logic                    M_REQ,
  output logic                    M_WE,
  output logic [ADDR_WIDTH-1:0]   M_ADDR,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_STRB,
  input  logic                    M_ACK,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
`ifdef CORE_MEM_TIMEOUT_EN
  output logic                    ERR,
`endif
  output logic                    MEM_WAIT
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  state_e                  state_q;
  gnt_t                    gnt_q;
  gnt_t                    last_q;
  gnt_t                    pick_c;
  logic                    m_req_q;
  logic                    m_we_q;
  logic [ADDR_WIDTH-1:0]   m_addr_q;
  logic [DATA_WIDTH-1:0]   m_wdata_q;
  logic [STRB_WIDTH-1:0]   m_strb_q;
  logic                    i_ack_q;
  logic                    d_ack_q;
  logic [DATA_WIDTH-1:0]   i_rdata_q;
  logic [DATA_WIDTH-1:0]   d_rdata_q;

`ifdef CORE_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`else
  // Watchdog limit has no hardware when the timeout feature is off.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  rr_arb2 u_arb (
    .i_req_i (I_REQ),
    .d_req_i (D_REQ),
    .last_i  (last_q),
    .gnt_c_o (pick_c)
  );

  // Transaction sequencer: grant, hold command until completion, pulse the ACK.
  always_ff @(posedge CCLK or posedge CRST) begin
    if (CRST) begin
      state_q   <= ST_IDLE;
      gnt_q     <= GNT_I;
      last_q    <= GNT_D;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_strb_q  <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef CORE_MEM_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
`ifdef CORE_MEM_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (I_REQ || D_REQ) begin
            gnt_q   <= pick_c;
            m_req_q <= 1'b1;
            state_q <= ST_CMD;
`ifdef CORE_MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
            if (pick_c == GNT_I) begin
              m_we_q    <= 1'b0;
              m_addr_q  <= I_ADDR;
              m_wdata_q <= '0;
              m_strb_q  <= '0;
            end else begin
              m_we_q    <= D_WE;
              m_addr_q  <= D_ADDR;
              m_wdata_q <= D_WDATA;
              m_strb_q  <= D_STRB;
            end
          end
        end
        ST_CMD: begin
          if (M_ACK) begin
            m_req_q <= 1'b0;
            state_q <= ST_RESP;
            if (gnt_q == GNT_I) begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= M_RDATA;
            end else begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= m_we_q ? '0 : M_RDATA;
            end
          end
`ifdef CORE_MEM_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            m_req_q <= 1'b0;
            state_q <= ST_RESP;
            err_q   <= 1'b1;
            if (gnt_q == GNT_I) begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= DATA_WIDTH'(TIMEOUT_FILL);
            end else begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= DATA_WIDTH'(TIMEOUT_FILL);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        ST_RESP: begin
          last_q  <= gnt_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign I_ACK    = i_ack_q;
  assign I_RDATA  = i_rdata_q;
  assign D_ACK    = d_ack_q;
  assign D_RDATA  = d_rdata_q;
  assign M_REQ    = m_req_q;
  assign M_WE     = m_we_q;
  assign M_ADDR   = m_addr_q;
  assign M_WDATA  = m_wdata_q;
  assign M_STRB   = m_strb_q;
`ifdef CORE_MEM_TIMEOUT_EN
  assign ERR      = err_q;
`endif

  // Stall the core while any requester is still waiting for its ACK.
  assign MEM_WAIT = (I_REQ & ~i_ack_q) | (D_REQ & ~d_ack_q);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: random traffic against a memory model.
`timescale 1ns/1ps
module tb_core_mem_arbiter;

  localparam int unsigned TMO = 8;

  logic        CCLK = 1'b0;
  logic        CRST;
  logic        I_REQ, I_ACK, D_REQ, D_WE, D_ACK, M_REQ, M_WE, M_ACK, MEM_WAIT;
  logic [31:0] I_ADDR, I_RDATA, D_ADDR, D_WDATA, D_RDATA, M_ADDR, M_WDATA, M_RDATA;
  logic [3:0]  D_STRB, M_STRB;
`ifdef CORE_MEM_TIMEOUT_EN
  logic        ERR;
`endif

  core_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .CCLK(CCLK), .CRST(CRST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_STRB(D_STRB),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_STRB(M_STRB),
    .M_ACK(M_ACK), .M_RDATA(M_RDATA),
`ifdef CORE_MEM_TIMEOUT_EN
    .ERR(ERR),
`endif
    .MEM_WAIT(MEM_WAIT)
  );

  always #5 CCLK = ~CCLK;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; } cmd_t;
  typedef struct { logic [31:0] data; logic err; } rsp_t;

  int n_cmp = 0;
  int n_bad = 0;

  cmd_t i_cmd_q[$], d_cmd_q[$];
  rsp_t i_exp_q[$], d_exp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] rsp_mem [logic [31:0]];
  logic [31:0] gnt_log[$];

  int rsp_dly    = -1;
  bit rsp_hold   = 1'b0;
  int spur_req_n = 0;
  bit tmo_mode   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Unwritten memory words read as address + 3.
  function automatic logic [31:0] fresh_word(input logic [31:0] a);
    return a + 32'h3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fresh_word(a);
  endfunction

  // Fetch request: push expectation, hold REQ until ACK, return at the edge after ACK.
  task automatic issue_i(input logic [31:0] a, output int lat);
    cmd_t c;
    rsp_t r;
    c.we = 1'b0; c.addr = a; c.wdata = '0; c.strb = '0;
    r.data = tmo_mode ? 32'hDEAD_BEEF : ref_rd(a);
    r.err  = tmo_mode;
    i_cmd_q.push_back(c);
    i_exp_q.push_back(r);
    I_REQ = 1'b1; I_ADDR = a;
    lat = 0;
    do begin @(negedge CCLK); lat++; end while (I_ACK !== 1'b1 && lat < 200);
    chk("i_ack_seen", I_ACK, 1'b1);
    @(posedge CCLK); #1;
  endtask

  task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] strb, output int lat);
    cmd_t c;
    rsp_t r;
    c.we = we; c.addr = a; c.wdata = wd; c.strb = strb;
    r.err = tmo_mode;
    if (tmo_mode) r.data = 32'hDEAD_BEEF;
    else if (we) begin
      r.data = '0;
      ref_mem[a] = merge(ref_rd(a), wd, strb);
    end else r.data = ref_rd(a);
    d_cmd_q.push_back(c);
    d_exp_q.push_back(r);
    D_REQ = 1'b1; D_WE = we; D_ADDR = a; D_WDATA = wd; D_STRB = strb;
    lat = 0;
    do begin @(negedge CCLK); lat++; end while (D_ACK !== 1'b1 && lat < 200);
    chk("d_ack_seen", D_ACK, 1'b1);
    @(posedge CCLK); #1;
  endtask

  // Downstream memory: answers after a delay; can also inject stray M_ACK pulses.
  initial begin
    int  spur_done;
    int  d;
    bit  ok;
    spur_done = 0;
    M_ACK = 1'b0; M_RDATA = '0;
    forever begin
      @(posedge CCLK); #1;
      if (spur_req_n != spur_done) begin
        spur_done++;
        M_RDATA = $urandom; M_ACK = 1'b1;
        @(posedge CCLK); #1;
        M_ACK = 1'b0;
      end else if (M_REQ === 1'b1 && !rsp_hold) begin
        d  = (rsp_dly >= 0) ? rsp_dly : int'($urandom_range(0, 4));
        ok = 1'b1;
        for (int k = 0; k < d; k++) begin
          @(posedge CCLK); #1;
          if (M_REQ !== 1'b1) begin ok = 1'b0; break; end
        end
        if (ok) begin
          if (M_WE) begin
            rsp_mem[M_ADDR] = merge(rsp_mem.exists(M_ADDR) ? rsp_mem[M_ADDR] : fresh_word(M_ADDR),
                                    M_WDATA, M_STRB);
            M_RDATA = $urandom;
          end else begin
            M_RDATA = rsp_mem.exists(M_ADDR) ? rsp_mem[M_ADDR] : fresh_word(M_ADDR);
          end
          M_ACK = 1'b1;
          @(posedge CCLK); #1;
          M_ACK = 1'b0; M_RDATA = $urandom;
        end
      end
    end
  end

  // Monitor: arbitration model, command checks, ACK/RDATA/MEM_WAIT scoreboard.
  bit          busy = 1'b0;
  bit          ack_v = 1'b0;
  logic        ack_port = 1'b0;
  logic        last_port = 1'b1;
  logic        ps_i = 1'b0, ps_d = 1'b0;
  int          m_cyc = 0;
  cmd_t        cur;
  logic [31:0] i_hold = '0, d_hold = '0;

  always @(negedge CCLK) begin
    logic e_i, e_d, e_err, win;
    rsp_t r;
    if (CRST === 1'b1) begin
      busy = 1'b0; ack_v = 1'b0; last_port = 1'b1;
      ps_i = 1'b0; ps_d = 1'b0; i_hold = '0; d_hold = '0;
    end else begin
      e_i   = ack_v && (ack_port == 1'b0);
      e_d   = ack_v && (ack_port == 1'b1);
      e_err = 1'b0;
      chk("i_ack", I_ACK, e_i);
      chk("d_ack", D_ACK, e_d);
      chk("mem_wait", MEM_WAIT, (I_REQ & ~e_i) | (D_REQ & ~e_d));
      if (ack_v) begin
        if (!ack_port) begin
          chk("i_exp_avail", i_exp_q.size() > 0, 1'b1);
          if (i_exp_q.size() > 0) begin r = i_exp_q.pop_front(); i_hold = r.data; e_err = r.err; end
        end else begin
          chk("d_exp_avail", d_exp_q.size() > 0, 1'b1);
          if (d_exp_q.size() > 0) begin r = d_exp_q.pop_front(); d_hold = r.data; e_err = r.err; end
        end
        chk("m_req_drop", M_REQ, 1'b0);
        ack_v = 1'b0;
        busy  = 1'b0;
      end else if (!busy && M_REQ === 1'b1) begin
        chk("grant_needs_req", ps_i | ps_d, 1'b1);
        win = (ps_i && ps_d) ? ~last_port : ps_d;
        if (!win) begin
          chk("i_cmd_avail", i_cmd_q.size() > 0, 1'b1);
          if (i_cmd_q.size() > 0) cur = i_cmd_q.pop_front();
        end else begin
          chk("d_cmd_avail", d_cmd_q.size() > 0, 1'b1);
          if (d_cmd_q.size() > 0) cur = d_cmd_q.pop_front();
        end
        last_port = win;
        ack_port  = win;
        busy      = 1'b1;
        m_cyc     = 0;
        gnt_log.push_back(M_ADDR);
      end
      chk("i_rdata", I_RDATA, i_hold);
      chk("d_rdata", D_RDATA, d_hold);
`ifdef CORE_MEM_TIMEOUT_EN
      chk("err", ERR, e_err);
`endif
      if (busy) begin
        chk("m_req", M_REQ, 1'b1);
        chk("m_we", M_WE, cur.we);
        chk("m_addr", M_ADDR, cur.addr);
        chk("m_wdata", M_WDATA, cur.wdata);
        chk("m_strb", M_STRB, cur.strb);
        m_cyc++;
        if (M_ACK === 1'b1) ack_v = 1'b1;
`ifdef CORE_MEM_TIMEOUT_EN
        else if (m_cyc == int'(TMO)) ack_v = 1'b1;
`endif
      end
      ps_i = I_REQ;
      ps_d = D_REQ;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    CRST = 1'b1;
    I_REQ = 1'b0; I_ADDR = '0;
    D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0; D_STRB = '0;
    repeat (3) @(negedge CCLK);
    chk("rst_m_req", M_REQ, 1'b0);
    chk("rst_m_we", M_WE, 1'b0);
    chk("rst_m_addr", M_ADDR, 32'h0);
    chk("rst_m_wdata", M_WDATA, 32'h0);
    chk("rst_m_strb", M_STRB, 4'h0);
    chk("rst_i_ack", I_ACK, 1'b0);
    chk("rst_d_ack", D_ACK, 1'b0);
    chk("rst_i_rdata", I_RDATA, 32'h0);
    chk("rst_d_rdata", D_RDATA, 32'h0);
    chk("rst_mem_wait", MEM_WAIT, 1'b0);
`ifdef CORE_MEM_TIMEOUT_EN
    chk("rst_err", ERR, 1'b0);
`endif
    CRST = 1'b0;
    @(posedge CCLK); #1;

    // Both ports held from reset: strict alternation starting with fetch.
    gnt_log.delete();
    fork
      begin
        int l1;
        issue_i(32'h0000_2000, l1); issue_i(32'h0000_2004, l1); I_REQ = 1'b0;
      end
      begin
        int l2;
        issue_d(1'b0, 32'h0000_4000, 32'h0, 4'h0, l2);
        issue_d(1'b1, 32'h0000_4004, 32'h1234_5678, 4'hF, l2); D_REQ = 1'b0;
      end
    join
    chk("gnt_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      chk("gnt_order0", gnt_log[0], 32'h0000_2000);
      chk("gnt_order1", gnt_log[1], 32'h0000_4000);
      chk("gnt_order2", gnt_log[2], 32'h0000_2004);
      chk("gnt_order3", gnt_log[3], 32'h0000_4004);
    end

    // Directed fetch and write with zero downstream wait: minimum latency.
    rsp_dly = 0;
    issue_i(32'h0000_0010, lat); I_REQ = 1'b0;
    chk("i_min_latency", lat, 3);
    issue_d(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'hF, lat);
    chk("d_min_latency", lat, 3);
    issue_d(1'b1, 32'h0000_0100, 32'h1111_2222, 4'b0101, lat);
    issue_d(1'b0, 32'h0000_0100, 32'h0, 4'h0, lat); D_REQ = 1'b0;

    // Long downstream wait: command must stay put, ACK only after M_ACK.
`ifdef CORE_MEM_TIMEOUT_EN
    rsp_dly = 5;
`else
    rsp_dly = 20;
`endif
    issue_i(32'h0000_2040, lat); I_REQ = 1'b0;
    chk("i_slow_latency", lat, 3 + rsp_dly);
    issue_d(1'b0, 32'h0000_0100, 32'h0, 4'h0, lat); D_REQ = 1'b0;
    chk("d_slow_latency", lat, 3 + rsp_dly);
    rsp_dly = -1;

    // Stray M_ACK while idle must not produce any ACK or RDATA change.
    spur_req_n++;
    repeat (4) begin @(posedge CCLK); #1; end

    // Random concurrent traffic.
    fork
      begin
        int l3;
        for (int n = 0; n < 30; n++) begin
          int gap;
          issue_i(32'h0000_2000 + (32'($urandom_range(0, 63)) << 2), l3);
          gap = int'($urandom_range(0, 2));
          if (gap > 0) begin
            I_REQ = 1'b0;
            repeat (gap) begin @(posedge CCLK); #1; end
          end
        end
        I_REQ = 1'b0;
      end
      begin
        int l4;
        for (int n = 0; n < 30; n++) begin
          int gap;
          issue_d(1'($urandom_range(0, 1)), 32'h0000_4000 + (32'($urandom_range(0, 15)) << 2),
                  32'($urandom), 4'($urandom_range(0, 15)), l4);
          gap = int'($urandom_range(0, 2));
          if (gap > 0) begin
            D_REQ = 1'b0;
            repeat (gap) begin @(posedge CCLK); #1; end
          end
        end
        D_REQ = 1'b0;
      end
    join

    // Reset in the middle of a command aborts it immediately.
    rsp_dly = 30;
    begin
      cmd_t c;
      rsp_t r;
      c.we = 1'b0; c.addr = 32'h0000_2100; c.wdata = '0; c.strb = '0;
      r.data = ref_rd(32'h0000_2100); r.err = 1'b0;
      i_cmd_q.push_back(c);
      i_exp_q.push_back(r);
      I_REQ = 1'b1; I_ADDR = 32'h0000_2100;
    end
    repeat (5) @(posedge CCLK);
    #3;
    CRST = 1'b1;
    #1;
    chk("abort_m_req", M_REQ, 1'b0);
    chk("abort_i_ack", I_ACK, 1'b0);
    chk("abort_d_ack", D_ACK, 1'b0);
    I_REQ = 1'b0;
    i_cmd_q.delete();
    i_exp_q.delete();
    @(negedge CCLK);
    @(negedge CCLK);
    CRST = 1'b0;
    rsp_dly = -1;
    @(posedge CCLK); #1;
    issue_i(32'h0000_0010, lat); I_REQ = 1'b0;

`ifdef CORE_MEM_TIMEOUT_EN
    // Silent downstream: watchdog completes the data read with ERR and fill data.
    rsp_hold = 1'b1;
    tmo_mode = 1'b1;
    issue_d(1'b0, 32'h0000_4000, 32'h0, 4'h0, lat); D_REQ = 1'b0;
    chk("tmo_latency", lat, int'(TMO) + 2);
    tmo_mode = 1'b0;
    spur_req_n++;
    repeat (4) begin @(posedge CCLK); #1; end
    rsp_hold = 1'b0;
    issue_d(1'b0, 32'h0000_0100, 32'h0, 4'h0, lat); D_REQ = 1'b0;
`endif

    repeat (3) @(negedge CCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
